// File: rtl/ones_cnt_pkg.sv
// Shared types and helpers for the round-robin ones-count scheduler.
package ones_cnt_pkg;

    localparam int unsigned N_REQ_DEF  = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned RR_MAX     = 32;
    localparam int unsigned RR_IDX_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sched_state_e;

    // First valid index at or after ptr, wrapping modulo n; returns 0 if none valid.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       ptr,
        input int unsigned       n = N_REQ_DEF
    );
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[RR_IDX_W-1:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/ones_count_serial.sv
// Bit-serial ones accumulator: the shared counting datapath.
module ones_count_serial
    import ones_cnt_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(din);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ones_count_sched.sv
// Round-robin scheduler sharing one serial ones counter among N_REQ requesters.
module ones_count_sched
    import ones_cnt_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1),
    parameter int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          rsp_count,
    output logic                      busy
);

    sched_state_e      state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   winner;
    logic [DATA_W-1:0] sel_word;
    logic              cnt_clr;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt_val;

    assign winner = ID_W'(rr_pick(RR_MAX'(req_valid), 32'(rr_ptr_q), N_REQ));

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                sel_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant is gated by reset so req_ready reads zero while reset is held.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid && !reset) begin
                    req_ready[winner] = 1'b1;
                    shreg_d           = sel_word;
                    id_d              = winner;
                    cnt_clr           = 1'b1;
                    bit_cnt_d         = '0;
                    state_d           = SHIFT;
                end
            end
            SHIFT: begin
                cnt_en    = 1'b1;
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rr_ptr_q  <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
        end
    end

    ones_count_serial #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .din  (shreg_q[0]),
        .count(cnt_val)
    );

    assign rsp_id    = id_q;
    assign rsp_count = cnt_val;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ones_count_sched.sv
// Scoreboard bench for ones_count_sched: directed requests, queued expectations, negedge monitor.
module tb_ones_count_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 2;

    typedef struct {
        int id;
        int cnt;
    } rsp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IW-1:0]   rsp_id;
    logic [CW-1:0]   rsp_count;
    logic            busy;

    int          want[N];
    int          served[N];
    logic [DW-1:0] words[N];
    logic [N-1:0]  hs;

    int   gq[$];
    rsp_t rq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int timeout_req = 0;
    bit rst_expect = 1'b1;
    bit bp_expect = 1'b0;
    bit gap_check = 1'b0;
    int bp_id = 0;
    int bp_cnt = 0;

    ones_count_sched #(
        .N_REQ (N),
        .DATA_W(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_count(rsp_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A requester stays valid while it still has words it wants served.
    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < int'(N); i++) begin
            req_valid[i]          = served[i] < want[i];
            req_data[i*DW +: DW]  = words[i];
        end
    end

    initial begin
        hs = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(N); i++) begin
                if (hs[i]) served[i] = served[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: invariants, grant order/timing, response scoreboard, phase checks.
    initial begin
        int   g;
        int   e;
        int   last_grant;
        int   timeout_seen;
        bit   gap_armed;
        bit   prev_valid;
        rsp_t r;
        last_grant   = 0;
        timeout_seen = 0;
        gap_armed    = 1'b0;
        prev_valid   = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) chk("count_zero_in_reset", int'(rsp_count), 0);
            chk("ready_onehot0", int'($onehot0(req_ready)), 1);
            chk("ready_only_idle", int'((|req_ready) && busy), 0);
            if (req_ready != '0) begin
                g = 0;
                for (int i = 0; i < int'(N); i++) if (req_ready[i]) g = i;
                if (gq.size() == 0) begin
                    chk("grant_unexpected", g, -1);
                end else begin
                    e = gq.pop_front();
                    chk("grant_id", g, e);
                end
                if (gap_check && gap_armed) chk("grant_gap", cyc - last_grant, int'(DW) + 2);
                gap_armed  = gap_check;
                last_grant = cyc;
            end
            if (rsp_valid && !prev_valid) chk("rsp_latency", cyc - last_grant, int'(DW) + 1);
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", int'(rsp_id), -1);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_id", int'(rsp_id), r.id);
                    chk("rsp_count", int'(rsp_count), r.cnt);
                end
            end
            if (bp_expect) begin
                chk("bp_valid", int'(rsp_valid), 1);
                chk("bp_id", int'(rsp_id), bp_id);
                chk("bp_count", int'(rsp_count), bp_cnt);
                chk("bp_no_ready", int'(req_ready), 0);
            end
            if (rst_expect) begin
                chk("rst_rsp_valid", int'(rsp_valid), 0);
                chk("rst_req_ready", int'(req_ready), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_rsp_id", int'(rsp_id), 0);
                chk("rst_rsp_count", int'(rsp_count), 0);
            end
            if (timeout_req != timeout_seen) begin
                chk("timeout", timeout_req, timeout_seen);
                timeout_seen = timeout_req;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rsp(input int id, input int cnt);
        rq.push_back('{id: id, cnt: cnt});
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (gq.size() == 0 && rq.size() == 0 && !busy && req_valid == '0) break;
            n++;
            if (n >= budget) begin
                timeout_req++;
                break;
            end
        end
    endtask

    task automatic wait_rsp_valid(input int budget);
        int n;
        n = 0;
        forever begin
            step();
            if (rsp_valid) break;
            n++;
            if (n >= budget) begin
                timeout_req++;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        forever begin
            step();
            if (busy) break;
            n++;
            if (n >= budget) begin
                timeout_req++;
                break;
            end
        end
    endtask

    task automatic do_reset();
        step();
        reset      = 1'b1;
        rst_expect = 1'b1;
        step();
        reset      = 1'b0;
        rst_expect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) words[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        rst_expect = 1'b0;

        // Single request: 0xB5 has five ones.
        words[0] = 8'hB5;
        gq.push_back(0);
        exp_rsp(0, 5);
        want[0] += 1;
        wait_drain(100);

        // All four at once from rr_ptr=0: served 0,1,2,3 ten cycles apart.
        do_reset();
        gap_check = 1'b1;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h0F; words[3] = 8'h81;
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3);
        exp_rsp(0, 0); exp_rsp(1, 8); exp_rsp(2, 4); exp_rsp(3, 2);
        for (int i = 0; i < int'(N); i++) want[i] += 1;
        wait_drain(200);
        gap_check = 1'b0;

        // Fairness: 1 and 3 both held valid, must alternate 1,3,1,3,1.
        step();
        words[1] = 8'h3C; words[3] = 8'h70;
        gq.push_back(1); gq.push_back(3); gq.push_back(1); gq.push_back(3); gq.push_back(1);
        exp_rsp(1, 4); exp_rsp(3, 3); exp_rsp(1, 4); exp_rsp(3, 3); exp_rsp(1, 4);
        want[1] += 3;
        want[3] += 2;
        wait_drain(300);

        // Backpressure: rr_ptr=2 so requester 2 wins; requester 0 waits through 5 stalled DONE cycles.
        step();
        rsp_ready = 1'b0;
        words[2] = 8'hA5; words[0] = 8'h12;
        gq.push_back(2); gq.push_back(0);
        exp_rsp(2, 4); exp_rsp(0, 2);
        want[2] += 1;
        want[0] += 1;
        bp_id  = 2;
        bp_cnt = 4;
        wait_rsp_valid(50);
        bp_expect = 1'b1;
        repeat (4) step();
        step();
        bp_expect = 1'b0;
        rsp_ready = 1'b1;
        wait_drain(100);

        // Reset at bit 3 of 0xFF; afterwards rr_ptr=0 so requester 0 beats requester 2.
        step();
        words[0] = 8'hFF;
        gq.push_back(0);
        want[0] += 2;
        wait_busy(50);
        repeat (3) step();
        words[2]   = 8'h11;
        want[2]   += 1;
        reset      = 1'b1;
        rst_expect = 1'b1;
        gq.push_back(0); gq.push_back(2);
        exp_rsp(0, 8); exp_rsp(2, 2);
        step();
        reset      = 1'b0;
        rst_expect = 1'b0;
        wait_drain(200);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ones_count_sched.md
# ones_count_sched

Round-robin scheduler that shares one bit-serial ones-counter datapath between `N_REQ` requesters. Each requester offers a `DATA_W`-bit word. The block grants one requester and shifts its word LSB-first through the serial ones counter. It then returns the population count, tagged with the requester index. It sits between the requester agents and the shared counting datapath and owns all sequencing of that datapath.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `DATA_W`, 8, word width in bits (≥1)
- `CNT_W`, `$clog2(DATA_W+1)`, count width; holds `DATA_W` without overflow
- `ID_W`, `$clog2(N_REQ)`, requester index width

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high; clears all state
- `req_valid`  in  `N_REQ`  requester i offers a word
- `req_data`  in  `N_REQ*DATA_W`  word i occupies bits `[i*DATA_W +: DATA_W]`
- `req_ready`  out  `N_REQ`  one-hot grant; a transfer occurs on `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts the result
- `rsp_id`  out  `ID_W`  index of the served requester
- `rsp_count`  out  `CNT_W`  number of 1 bits in the served word
- `busy`  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, select the winner by round-robin starting at `rr_ptr` and wrapping.
  - Drive `req_ready[winner]=1` combinationally in the same cycle. All other `req_ready` bits are 0.
  - On that edge: capture `req_data` word into the shift register, latch `rsp_id=winner`, clear the serial counter, load `bit_cnt=0`, go to SHIFT.
- SHIFT:
  - Each cycle, feed `shreg[0]` to the counter with enable high, then shift `shreg` right by 1 and increment `bit_cnt`.
  - When `bit_cnt==DATA_W-1`, go to DONE after that cycle.
  - `req_ready` is all-zero.
- DONE:
  - `rsp_valid=1`, `rsp_count`=counter value, `rsp_id` held.
  - On `rsp_valid & rsp_ready`, set `rr_ptr=(winner+1) mod N_REQ`, then go to IDLE.
  - Without `rsp_ready`, hold all outputs stable indefinitely.
- Round-robin:
  - `rr_ptr` resets to 0.
  - `rr_ptr` advances only on response completion, never on requests that were not granted.
- Requester contract: once `req_valid[i]` is high, the requester holds it and its data until `req_ready[i]` is seen. The block does not check this.
- Counter arithmetic:
  - Unsigned increment by `din`.
  - Never exceeds `DATA_W`, so no wrap is possible.
  - Counter is 0 whenever `reset` is high. A nonzero count implies reset is deasserted.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_count=0`, `busy=0`, `rr_ptr=0`, counter=0.
- Accept at cycle T (IDLE).
  - Bit k is counted in cycle T+1+k.
  - `rsp_valid` rises at T+DATA_W+1.
  - Latency from accept to response is DATA_W+1 cycles.
- With `rsp_ready` held high, `rsp_valid` lasts 1 cycle. The next accept is possible at T+DATA_W+2, so the peak rate is one word per DATA_W+2 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep `req_valid` high and wait.
- `req_valid` dropping in a cycle where it is not granted: no effect.
- Reset mid-operation (SHIFT or DONE):
  - Asynchronous return to IDLE with reset values.
  - In-flight word is discarded and no response is produced.
  - The requester is not re-granted unless it is still valid.
- `busy` is registered from state: 1 in SHIFT and DONE.

## Structure
- Package `ones_cnt_pkg`:
  - State enum `sched_state_e` {IDLE, SHIFT, DONE}.
  - Default-parameter constants.
  - Function `rr_pick(valid, ptr)` returning the winner index.
- Sub-module `ones_count_serial`:
  - Ports: `clk`, `reset`, `clr`, `en`, `din`, `count[CNT_W]`.
  - Function: bit-serial accumulator with synchronous `clr` and asynchronous `reset`; this is the shared datapath.
- Top level: FSM, shift register, `bit_cnt`, `rr_ptr`, response registers.

## Test plan
- Single request: `req_valid=4'b0001`, word `8'hB5`, `rsp_ready=1` → `req_ready[0]` for 1 cycle; `rsp_valid` 9 cycles later with `rsp_count=5`, `rsp_id=0`.
- All four requesters valid, with words `8'h00`, `8'hFF`, `8'h0F`, `8'h81` → served in order 0,1,2,3 with counts 0, 8, 4, 2; gaps of 10 cycles between grants.
- Fairness: requesters 1 and 3 held valid continuously after serving 1 → the next grant is 3, then 1, alternating; requester 1 is never served twice in a row.
- Backpressure: `rsp_ready=0` for 5 cycles in DONE → `rsp_valid`, `rsp_count` and `rsp_id` stable; no `req_ready` asserted; completion on the 6th cycle.
- Reset during SHIFT at bit 3 of `8'hFF` → next cycle all outputs at reset values; no `rsp_valid`; after release, requester 0 still valid is granted first (`rr_ptr=0`).
- Invariant assertions for all tests:
  - `rsp_count!=0` implies `reset==0`.
  - `req_ready` is one-hot or zero.
  - `req_ready` is nonzero only in IDLE.
